// File: rtl/sd_spi_pkg.sv
// Shared types, protocol constants and the CRC7 step function for the SPI-mode SD command path.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CMD,
    ST_RESP,
    ST_EXT,
    ST_TOKEN,
    ST_TRAIL
  } sd_state_e;

  localparam logic [1:0] SD_START_BITS = 2'b01;
  localparam logic [7:0] SD_TOKEN      = 8'hFE;
  localparam logic [7:0] SD_IDLE_BYTE  = 8'hFF;

  // CRC7 (x^7 + x^3 + 1), one byte folded in MSB first
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic [7:0] d;
    logic       fb;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[6] ^ d[7];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-wise CRC7 accumulator; clr restarts from zero and may coincide with en.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = clr ? '0 : crc_q;
    if (en) crc_d = crc7_byte(crc_d, data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SPI-mode SD command sequencer: dummy clocks, framed command with CRC7, R1/R3/R7 and token polling.
module sd_cmd_engine #(
  parameter int unsigned INIT_BYTES = 10,
  parameter int unsigned RESP_POLL  = 8,
  parameter int unsigned TOKEN_POLL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        resp_ext,
  input  logic        want_token,
  input  logic        keep_cs,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  input  logic [7:0]  rx_byte,
  output logic        cs_n,
  output logic        done,
  output logic [7:0]  r1,
  output logic [31:0] resp_data,
  output logic        err_timeout
);
  import sd_spi_pkg::*;

  localparam int unsigned BMAX = (INIT_BYTES > 6) ? INIT_BYTES : 6;
  localparam int unsigned BW   = $clog2(BMAX + 1);
  localparam int unsigned RW   = $clog2(RESP_POLL + 1);
  localparam int unsigned TW   = $clog2(TOKEN_POLL + 1);

  sd_state_e   state_q, state_d;
  logic        cs_n_q, cs_n_d, tx_start_q, tx_start_d, pend_q, pend_d;
  logic        done_q, done_d, err_q, err_d;
  logic [7:0]  tx_byte_q, tx_byte_d, r1_q, r1_d;
  logic [31:0] resp_q, resp_d, arg_q, arg_d;
  logic [5:0]  idx_q, idx_d;
  logic        ext_q, ext_d, tok_q, tok_d, keep_q, keep_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        crc_clr, crc_en;
  logic [6:0]  crc_val;
  logic        take;

  assign take = tx_done & pend_q;

  sd_crc7 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (tx_byte_d),
    .crc  (crc_val)
  );

  always_comb begin
    state_d = state_q;  cs_n_d = cs_n_q;   tx_start_d = 1'b0; pend_d = pend_q;
    done_d  = 1'b0;     err_d  = err_q;    tx_byte_d  = tx_byte_q;
    r1_d    = r1_q;     resp_d = resp_q;   arg_d = arg_q;     idx_d = idx_q;
    ext_d   = ext_q;    tok_d  = tok_q;    keep_d = keep_q;
    cnt_d   = cnt_q;    rcnt_d = rcnt_q;   tcnt_d = tcnt_q;
    crc_clr = 1'b0;     crc_en = 1'b0;
    if (take) pend_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          err_d   = 1'b0;
        end else if (cmd_valid) begin
          state_d = ST_CMD;
          idx_d = cmd_idx;  arg_d = cmd_arg;
          ext_d = resp_ext; tok_d = want_token; keep_d = keep_cs;
          r1_d  = SD_IDLE_BYTE;
          err_d = 1'b0;
        end
      end
      ST_INIT: if (take) begin
        if (cnt_q == BW'(INIT_BYTES - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          tx_start_d = 1'b1;
        end
      end
      ST_CMD: if (take) begin
        if (cnt_q == BW'(5)) state_d = ST_RESP;
        else begin
          cnt_d      = cnt_q + 1'b1;
          tx_start_d = 1'b1;
          case (cnt_q)
            BW'(0):  tx_byte_d = arg_q[31:24];
            BW'(1):  tx_byte_d = arg_q[23:16];
            BW'(2):  tx_byte_d = arg_q[15:8];
            BW'(3):  tx_byte_d = arg_q[7:0];
            default: tx_byte_d = {crc_val, 1'b1};
          endcase
          crc_en = (cnt_q != BW'(4));
        end
      end
      ST_RESP: if (take) begin
        if (!rx_byte[7]) begin
          r1_d = rx_byte;
          if (ext_q)                          state_d = ST_EXT;
          else if (tok_q && rx_byte == 8'h00) state_d = ST_TOKEN;
          else                                state_d = ST_TRAIL;
        end else if (rcnt_q == RW'(RESP_POLL - 1)) begin
          rcnt_d  = RW'(RESP_POLL);
          err_d   = 1'b1;
          state_d = ST_TRAIL;
        end else begin
          rcnt_d     = rcnt_q + 1'b1;
          tx_start_d = 1'b1;
        end
      end
      ST_EXT: if (take) begin
        resp_d = {resp_q[23:0], rx_byte};
        if (cnt_q == BW'(3)) state_d = (tok_q && r1_q == 8'h00) ? ST_TOKEN : ST_TRAIL;
        else begin
          cnt_d      = cnt_q + 1'b1;
          tx_start_d = 1'b1;
        end
      end
      ST_TOKEN: if (take) begin
        if (rx_byte == SD_TOKEN) begin
          // keep_cs with a token: skip the trailing byte so the data phase follows immediately
          if (keep_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else state_d = ST_TRAIL;
        end else if (tcnt_q == TW'(TOKEN_POLL - 1)) begin
          tcnt_d  = TW'(TOKEN_POLL);
          err_d   = 1'b1;
          state_d = ST_TRAIL;
        end else begin
          tcnt_d     = tcnt_q + 1'b1;
          tx_start_d = 1'b1;
        end
      end
      ST_TRAIL: if (take) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entry into any byte-sending state issues its first byte and sets CS alongside tx_start
    if (state_d != state_q && state_d != ST_IDLE) begin
      tx_start_d = 1'b1;
      cnt_d = '0; rcnt_d = '0; tcnt_d = '0;
      tx_byte_d = (state_d == ST_CMD) ? {SD_START_BITS, cmd_idx} : SD_IDLE_BYTE;
      if (state_d == ST_CMD) begin
        cs_n_d  = 1'b0;
        crc_clr = 1'b1;
        crc_en  = 1'b1;
      end else if (state_d == ST_INIT || state_d == ST_TRAIL) cs_n_d = 1'b1;
    end
    if (tx_start_d) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;  cs_n_q <= 1'b1;  tx_start_q <= 1'b0;  pend_q <= 1'b0;
      done_q  <= 1'b0;     err_q  <= 1'b0;  tx_byte_q  <= SD_IDLE_BYTE;
      r1_q    <= SD_IDLE_BYTE;  resp_q <= '0;  arg_q <= '0;  idx_q <= '0;
      ext_q   <= 1'b0;     tok_q  <= 1'b0;  keep_q <= 1'b0;
      cnt_q   <= '0;       rcnt_q <= '0;    tcnt_q <= '0;
    end else begin
      state_q <= state_d;  cs_n_q <= cs_n_d;  tx_start_q <= tx_start_d;  pend_q <= pend_d;
      done_q  <= done_d;   err_q  <= err_d;   tx_byte_q  <= tx_byte_d;
      r1_q    <= r1_d;     resp_q <= resp_d;  arg_q <= arg_d;  idx_q <= idx_d;
      ext_q   <= ext_d;    tok_q  <= tok_d;   keep_q <= keep_d;
      cnt_q   <= cnt_d;    rcnt_q <= rcnt_d;  tcnt_q <= tcnt_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE) && !init_req;
  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign cs_n        = cs_n_q;
  assign done        = done_q;
  assign r1          = r1_q;
  assign resp_data   = resp_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a latency-2 byte shifter model fed from a reply queue.
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        rst, init_req, cmd_valid, cmd_ready;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        resp_ext, want_token, keep_cs;
  logic        tx_start, tx_done, cs_n, done, err_timeout;
  logic [7:0]  tx_byte, rx_byte, r1;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  sd_cmd_engine #(.INIT_BYTES(10), .RESP_POLL(8), .TOKEN_POLL(1024)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .resp_ext(resp_ext), .want_token(want_token),
    .keep_cs(keep_cs), .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
    .rx_byte(rx_byte), .cs_n(cs_n), .done(done), .r1(r1), .resp_data(resp_data),
    .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sent[$];
  logic       cs_log[$];
  logic [7:0] rxq[$];
  int         busy = 0;
  logic       ok, cs_at_done;

  // Shifter model: logs each started byte, answers two cycles later with the next queued reply
  initial begin
    tx_done = 1'b0;
    rx_byte = 8'hFF;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          rx_byte = (rxq.size() > 0) ? rxq.pop_front() : 8'hFF;
          tx_done = 1'b1;
        end
      end else if (tx_start) begin
        sent.push_back(tx_byte);
        cs_log.push_back(cs_n);
        busy = 2;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    sent.delete();
    cs_log.delete();
  endtask

  task automatic push6ff();
    for (int i = 0; i < 6; i++) rxq.push_back(8'hFF);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic ext, input logic tok, input logic keep);
    clear_logs();
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; resp_ext = ext; want_token = tok; keep_cs = keep;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        cs_at_done = cs_n;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  function automatic logic [63:0] first8();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], (i < sent.size()) ? sent[i] : 8'h00};
    return v;
  endfunction

  function automatic int count_not_ff();
    int n = 0;
    foreach (sent[i]) if (sent[i] != 8'hFF) n++;
    return n;
  endfunction

  function automatic int count_cs_high();
    int n = 0;
    foreach (cs_log[i]) if (cs_log[i]) n++;
    return n;
  endfunction

  initial begin
    int n0;
    rst = 1'b1; init_req = 1'b0; cmd_valid = 1'b0;
    cmd_idx = '0; cmd_arg = '0; resp_ext = 1'b0; want_token = 1'b0; keep_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(cs_n), 64'd1);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'hFF);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_r1", 64'(r1), 64'hFF);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;

    // Init: ten 0xFF bytes with CS high
    clear_logs();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
    wait_done(200, "init");
    chk("init_nbytes", 64'(sent.size()), 64'd10);
    chk("init_non_ff", 64'(count_not_ff()), 64'd0);
    chk("init_cs_high", 64'(count_cs_high()), 64'd10);
    chk("init_err", 64'(err_timeout), 64'd0);
    chk("init_cs_done", 64'(cs_at_done), 64'd1);

    // CMD0: card answers FF then 01
    push6ff(); rxq.push_back(8'hFF); rxq.push_back(8'h01);
    issue(6'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_done(300, "cmd0");
    chk("cmd0_bytes", first8(), 64'h40000000_0095FFFF);
    chk("cmd0_nbytes", 64'(sent.size()), 64'd9);
    chk("cmd0_trail_byte", 64'(sent[8]), 64'hFF);
    chk("cmd0_trail_cs", 64'(cs_log[8]), 64'd1);
    chk("cmd0_cs_low", 64'(count_cs_high()), 64'd1);
    chk("cmd0_r1", 64'(r1), 64'h01);
    chk("cmd0_err", 64'(err_timeout), 64'd0);

    // CMD8 with R7 tail
    push6ff();
    rxq.push_back(8'h01); rxq.push_back(8'h00); rxq.push_back(8'h00);
    rxq.push_back(8'h01); rxq.push_back(8'hAA);
    issue(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 1'b0);
    wait_done(300, "cmd8");
    chk("cmd8_bytes", first8(), 64'h48000001_AA87FFFF);
    chk("cmd8_nbytes", 64'(sent.size()), 64'd12);
    chk("cmd8_resp", 64'(resp_data), 64'h0000_01AA);
    chk("cmd8_r1", 64'(r1), 64'h01);

    // CMD17 token on third poll, CS kept
    push6ff();
    rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'hFF); rxq.push_back(8'hFE);
    issue(6'd17, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
    wait_done(300, "cmd17");
    chk("cmd17_byte0", 64'(sent[0]), 64'h51);
    chk("cmd17_nbytes", 64'(sent.size()), 64'd10);
    chk("cmd17_cs_done", 64'(cs_at_done), 64'd0);
    chk("cmd17_err", 64'(err_timeout), 64'd0);
    chk("cmd17_r1", 64'(r1), 64'h00);
    repeat (5) @(negedge clk);
    chk("cmd17_cs_held", 64'(cs_n), 64'd0);
    chk("cmd17_ready", 64'(cmd_ready), 64'd1);

    // Card never answers: 8 polls then trailing byte releases CS
    issue(6'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    wait_done(300, "nor1");
    chk("nor1_nbytes", 64'(sent.size()), 64'd15);
    chk("nor1_err", 64'(err_timeout), 64'd1);
    chk("nor1_r1", 64'(r1), 64'hFF);
    chk("nor1_cs_done", 64'(cs_at_done), 64'd1);

    // Nonzero R1 skips the token wait without error
    push6ff(); rxq.push_back(8'h05);
    issue(6'd17, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_done(300, "r1bad");
    chk("r1bad_nbytes", 64'(sent.size()), 64'd8);
    chk("r1bad_err", 64'(err_timeout), 64'd0);
    chk("r1bad_r1", 64'(r1), 64'h05);
    chk("r1bad_cs_done", 64'(cs_at_done), 64'd1);

    // Token never arrives: 1024 polls then timeout
    push6ff(); rxq.push_back(8'h00);
    issue(6'd17, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_done(8000, "notok");
    chk("notok_nbytes", 64'(sent.size()), 64'd1032);
    chk("notok_err", 64'(err_timeout), 64'd1);
    chk("notok_cs_done", 64'(cs_at_done), 64'd1);

    // Reset during the argument bytes
    issue(6'd17, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sent.size() >= 3) begin ok = 1'b1; break; end
    end
    chk("rstmid_reached_arg", 64'(ok), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_cs_n", 64'(cs_n), 64'd1);
    chk("rstmid_ready", 64'(cmd_ready), 64'd1);
    chk("rstmid_tx_start", 64'(tx_start), 64'd0);
    rst = 1'b0;
    n0 = sent.size();
    repeat (20) @(negedge clk);
    chk("rstmid_no_more_tx", 64'(sent.size()), 64'(n0));
    rxq.delete();

    // init_req beats a simultaneous cmd_valid
    clear_logs();
    @(negedge clk);
    init_req = 1'b1; cmd_valid = 1'b1; cmd_idx = 6'd0; cmd_arg = '0;
    #1;
    chk("prio_ready_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    init_req = 1'b0; cmd_valid = 1'b0;
    wait_done(200, "prio");
    chk("prio_nbytes", 64'(sent.size()), 64'd10);
    chk("prio_non_ff", 64'(count_not_ff()), 64'd0);
    chk("prio_cs_high", 64'(count_cs_high()), 64'd10);
    repeat (20) @(negedge clk);
    chk("prio_no_cmd", 64'(sent.size()), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
